// File: rtl/river_crossing_planner_pkg.sv
// Shared types and the bank safety rule for the river-crossing planner.
// Bank vectors are {m,w,g,c}; 0 = near bank, 1 = far bank.
package river_pkg;

  localparam int BANK_M = 3;
  localparam int BANK_W = 2;
  localparam int BANK_G = 1;
  localparam int BANK_C = 0;

  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_W    = 2'd1,
    MV_G    = 2'd2,
    MV_C    = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_STUCK = 2'd3
  } state_e;

  // An item left without the man must not share a bank with what it eats.
  function automatic logic is_safe(input logic [3:0] b);
    logic wg_ok;
    logic gc_ok;
    wg_ok = (b[BANK_W] == b[BANK_M]) || (b[BANK_W] != b[BANK_G]);
    gc_ok = (b[BANK_G] == b[BANK_M]) || (b[BANK_G] != b[BANK_C]);
    return wg_ok && gc_ok;
  endfunction

endpackage

// File: rtl/river_crossing_planner_move_eval.sv
// Evaluates one candidate crossing: resulting bank vector and whether the
// move is legal (item beside the man, result safe, result not yet visited).
module river_move_eval
  import river_pkg::*;
(
  input  logic [3:0]  bank,
  input  move_e       move,
  input  logic [15:0] visited,
  output logic [3:0]  next_bank,
  output logic        legal
);

  logic item_ok;

  always_comb begin
    next_bank         = bank;
    item_ok           = 1'b1;
    next_bank[BANK_M] = ~bank[BANK_M];
    case (move)
      MV_W: begin
        next_bank[BANK_W] = ~bank[BANK_W];
        item_ok           = (bank[BANK_W] == bank[BANK_M]);
      end
      MV_G: begin
        next_bank[BANK_G] = ~bank[BANK_G];
        item_ok           = (bank[BANK_G] == bank[BANK_M]);
      end
      MV_C: begin
        next_bank[BANK_C] = ~bank[BANK_C];
        item_ok           = (bank[BANK_C] == bank[BANK_M]);
      end
      default: ;
    endcase
    legal = item_ok && is_safe(next_bank) && !visited[next_bank];
  end

endmodule

// File: rtl/river_crossing_planner.sv
// Greedy wolf/goat/cabbage move generator driving the crossing model's selects.
// Optional properties are compiled in with `define RIVER_PLANNER_FORMAL_EN.
module river_crossing_planner
  import river_pkg::*;
#(
  parameter int MAX_MOVES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  output logic       sel_w,
  output logic       sel_g,
  output logic       sel_c,
  output logic [3:0] bank,
  output logic       busy,
  output logic       done,
  output logic       stuck,
  output logic [3:0] moves
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_MOVES);

  state_e      state_q, state_d;
  logic [3:0]  bank_q, bank_d;
  logic [15:0] visited_q, visited_d;
  logic [3:0]  moves_q, moves_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        stuck_q, stuck_d;

  logic [3:0] cand_next [4];
  logic [3:0] cand_legal;
  move_e      pick;
  logic [3:0] pick_next;
  logic       any_legal;
  logic       run;
  logic       max_hit;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_cand
      river_move_eval u_eval (
        .bank      (bank_q),
        .move      (move_e'(2'(i))),
        .visited   (visited_q),
        .next_bank (cand_next[i]),
        .legal     (cand_legal[i])
      );
    end
  endgenerate

  // Lowest index wins: NONE, then W, G, C.
  always_comb begin
    pick      = MV_NONE;
    pick_next = bank_q;
    any_legal = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (cand_legal[k]) begin
        any_legal = 1'b1;
        pick      = move_e'(2'(k));
        pick_next = cand_next[k];
      end
    end
  end

  assign run     = (state_q == ST_RUN);
  assign max_hit = (moves_q == MAX_CNT);

  assign sel_w = run && any_legal && (pick == MV_W);
  assign sel_g = run && any_legal && (pick == MV_G);
  assign sel_c = run && any_legal && (pick == MV_C);

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    visited_d = visited_q;
    moves_d   = moves_q;
    busy_d    = busy_q;
    done_d    = done_q;
    stuck_d   = stuck_q;
    case (state_q)
      ST_RUN: begin
        if (!any_legal || max_hit) begin
          state_d = ST_STUCK;
          busy_d  = 1'b0;
          stuck_d = 1'b1;
        end else if (step) begin
          bank_d               = pick_next;
          visited_d[pick_next] = 1'b1;
          moves_d              = moves_q + 4'd1;
          // Completion outranks the crossing limit on the final move.
          if (pick_next == 4'hF) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (moves_q + 4'd1 == MAX_CNT) begin
            state_d = ST_STUCK;
            busy_d  = 1'b0;
            stuck_d = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d   = ST_RUN;
          bank_d    = 4'b0000;
          visited_d = 16'h0001;
          moves_d   = 4'd0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          stuck_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bank_q    <= 4'b0000;
      visited_q <= 16'h0000;
      moves_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      visited_q <= visited_d;
      moves_q   <= moves_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      stuck_q   <= stuck_d;
    end
  end

  assign bank  = bank_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stuck = stuck_q;
  assign moves = moves_q;

`ifdef RIVER_PLANNER_FORMAL_EN
  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0({sel_w, sel_g, sel_c}));
  a_bank_safe: assert property (@(posedge clk) disable iff (rst)
    is_safe(bank_q));
  a_done_stuck_excl: assert property (@(posedge clk) disable iff (rst)
    !(done_q && stuck_q));
  a_visit_fresh: assert property (@(posedge clk) disable iff (rst)
    (run && any_legal && !max_hit && step) |-> !visited_q[pick_next]);
  // Shortest reach: start edge plus seven crossings.
  c_done: cover property (@(posedge clk) disable iff (rst) done_q);
`endif

endmodule

// File: tb/tb_river_crossing_planner.sv
// Scoreboard bench: a positional model of the puzzle predicts every cycle's
// outputs for two planners (crossing limits 15 and 3) sharing one stimulus.
module tb_river_crossing_planner;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] bank;
    logic [3:0] moves;
    logic [2:0] flags;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic step = 1'b0;

  logic       sel_w0, sel_g0, sel_c0, busy0, done0, stuck0;
  logic [3:0] bank0, moves0;
  logic       sel_w1, sel_g1, sel_c1, busy1, done1, stuck1;
  logic [3:0] bank1, moves1;

  always #5 clk = ~clk;

  river_crossing_planner #(.MAX_MOVES(15)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .sel_w(sel_w0), .sel_g(sel_g0), .sel_c(sel_c0), .bank(bank0),
    .busy(busy0), .done(done0), .stuck(stuck0), .moves(moves0)
  );

  river_crossing_planner #(.MAX_MOVES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .sel_w(sel_w1), .sel_g(sel_g1), .sel_c(sel_c1), .bank(bank1),
    .busy(busy1), .done(done1), .stuck(stuck1), .moves(moves1)
  );

  int n_pass = 0;
  int n_total = 0;
  rec_t exp_q0 [$];
  rec_t exp_q1 [$];

  // Model: pos[0..3] = man, wolf, goat, cabbage; phase 0 idle 1 run 2 done 3 stuck.
  int m_phase [2];
  bit m_pos [2][4];
  bit m_seen [2][16];
  int m_moves [2];
  int m_max [2];

  function automatic int enc(input int d);
    return int'(m_pos[d][0]) * 8 + int'(m_pos[d][1]) * 4 + int'(m_pos[d][2]) * 2 + int'(m_pos[d][3]);
  endfunction

  function automatic void model_reset(input int d);
    m_phase[d] = 0;
    m_moves[d] = 0;
    for (int k = 0; k < 4; k++) m_pos[d][k] = 1'b0;
    for (int k = 0; k < 16; k++) m_seen[d][k] = 1'b0;
  endfunction

  // First legal crossing in order: alone, wolf, goat, cabbage; -1 if none.
  function automatic int best_cand(input int d, output int nxt);
    bit q [4];
    int code;
    best_cand = -1;
    nxt = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) q[k] = m_pos[d][k];
      if (c != 0 && q[c] != q[0]) continue;
      q[0] = !q[0];
      if (c != 0) q[c] = !q[c];
      if ((q[1] == q[2] && q[0] != q[1]) || (q[2] == q[3] && q[0] != q[2])) continue;
      code = int'(q[0]) * 8 + int'(q[1]) * 4 + int'(q[2]) * 2 + int'(q[3]);
      if (m_seen[d][code]) continue;
      if (best_cand < 0) begin
        best_cand = c;
        nxt = code;
      end
    end
  endfunction

  function automatic rec_t model_out(input int d);
    rec_t r;
    int c, nxt;
    c = best_cand(d, nxt);
    r.sel = 3'b000;
    if (m_phase[d] == 1) begin
      if (c == 1) r.sel = 3'b100;
      if (c == 2) r.sel = 3'b010;
      if (c == 3) r.sel = 3'b001;
    end
    r.bank  = 4'(enc(d));
    r.moves = 4'(m_moves[d]);
    r.flags = {m_phase[d] == 1, m_phase[d] == 2, m_phase[d] == 3};
    return r;
  endfunction

  function automatic void model_edge(input int d, input bit s, input bit st);
    int c, nxt;
    if (m_phase[d] != 1) begin
      if (s) begin
        model_reset(d);
        m_phase[d] = 1;
        m_seen[d][0] = 1'b1;
      end
    end else begin
      c = best_cand(d, nxt);
      if (c < 0 || m_moves[d] == m_max[d]) begin
        m_phase[d] = 3;
      end else if (st) begin
        for (int k = 0; k < 4; k++) m_pos[d][k] = nxt[3 - k];
        m_seen[d][nxt] = 1'b1;
        m_moves[d]++;
        if (nxt == 15) m_phase[d] = 2;
        else if (m_moves[d] == m_max[d]) m_phase[d] = 3;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // One cycle: record what the DUTs should show now, then drive the next edge.
  task automatic cycle(input bit s, input bit st);
    @(posedge clk);
    #1;
    start = s;
    step  = st;
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
    model_edge(0, s, st);
    model_edge(1, s, st);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #1;
    start = 1'b0;
    step  = 1'b0;
    rst   = 1'b1;
    model_reset(0);
    model_reset(1);
    #2;
    rst = 1'b0;
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
  endtask

  // Monitor: compares whatever the DUTs present against queued predictions.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        r = exp_q0.pop_front();
        chk("m15_sel", {sel_w0, sel_g0, sel_c0}, r.sel);
        chk("m15_bank", bank0, r.bank);
        chk("m15_moves", moves0, r.moves);
        chk("m15_busy_done_stuck", {busy0, done0, stuck0}, r.flags);
      end
      if (exp_q1.size() > 0) begin
        r = exp_q1.pop_front();
        chk("m3_sel", {sel_w1, sel_g1, sel_c1}, r.sel);
        chk("m3_bank", bank1, r.bank);
        chk("m3_moves", moves1, r.moves);
        chk("m3_busy_done_stuck", {busy1, done1, stuck1}, r.flags);
      end
    end
  end

  initial begin
    m_max[0] = 15;
    m_max[1] = 3;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (2) cycle(1'b0, 1'b0);

    // Start with step held high: full solve, and limit-3 planner sticks.
    cycle(1'b1, 1'b1);
    repeat (9) cycle(1'b0, 1'b1);

    // Restart from DONE with step also high, then alternate step; start mid-run.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 18; i++) cycle(i == 4, (i % 2) == 0);

    // Async reset after the fourth applied move, then a clean solve.
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b1);
    async_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (9) cycle(1'b0, 1'b1);

    for (int i = 0; i < 150; i++)
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);

    cycle(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
